// File: rtl/rv_alu1_fifo.sv
// Execute-stage-1 entry buffer: a DEPTH-entry valid/ready FIFO of decoded instructions.
// The head entry drives the ALU operands, the jump/branch target and a misalignment flag.
package rv_alu1_fifo_pkg;
    typedef struct packed {
        logic [3:0] op;
        logic       div_mux;
    } alu_ctrl_t;

    typedef logic [2:0] alu_res_t;
    typedef logic [2:0] res_src_t;

    typedef struct packed {
        logic i;
        logic j;
    } src_op2_t;
endpackage

module rv_alu1_fifo
    import rv_alu1_fifo_pkg::*;
#(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int DEPTH            = 2,
    parameter int C_EXT            = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // o_ready/o_valid depend only on the registered count.
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [IADDR_SPACE_BITS-1:1]   i_pc,
    input  logic [IADDR_SPACE_BITS-1:1]   i_pc_next,
    input  logic [IADDR_SPACE_BITS-1:1]   i_ret_addr,
    input  logic [4:0]                    i_rs1,
    input  logic [4:0]                    i_rs2,
    input  logic [4:0]                    i_rd,
    input  logic [31:0]                   i_imm_i,
    input  logic [31:0]                   i_imm_j,
    input  logic [2:0]                    i_funct3,
    input  alu_ctrl_t                     i_alu_ctrl,
    input  alu_res_t                      i_alu_res,
    input  res_src_t                      i_res_src,
    input  src_op2_t                      i_op2_src,
    input  logic                          i_op1_src,
    input  logic                          i_reg_write,
    input  logic                          i_inst_jal,
    input  logic                          i_inst_jalr,
    input  logic                          i_inst_mret,
    input  logic                          i_inst_branch,
    input  logic                          i_inst_store,
    input  logic                          i_to_trap,
    input  logic                          i_branch_pred,
    input  logic [31:0]                   i_reg1_data,
    input  logic [31:0]                   i_reg2_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [4:0]                    o_rs1,
    output logic [4:0]                    o_rs2,
    output logic [4:0]                    o_rd,
    output logic [2:0]                    o_funct3,
    output alu_ctrl_t                     o_alu_ctrl,
    output alu_res_t                      o_res,
    output res_src_t                      o_res_src,
    output logic [IADDR_SPACE_BITS-1:1]   o_pc,
    output logic [IADDR_SPACE_BITS-1:1]   o_pc_next,
    output logic                          o_branch_pred,
    output logic                          o_reg_write,
    output logic                          o_store,
    output logic                          o_inst_branch,
    output logic                          o_to_trap,
    output logic                          o_inst_jal_jalr,
    output logic [31:0]                   o_op1,
    output logic [31:0]                   o_op2,
    output logic [31:0]                   o_reg_data1,
    output logic [31:0]                   o_reg_data2,
    output logic [IADDR_SPACE_BITS-1:1]   o_pc_target,
    output logic                          o_target_misaligned,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam bit NO_C  = (C_EXT == 0);

    typedef struct packed {
        logic [IADDR_SPACE_BITS-1:1] pc;
        logic [IADDR_SPACE_BITS-1:1] pc_next;
        logic [4:0]                  rs1;
        logic [4:0]                  rs2;
        logic [4:0]                  rd;
        logic [31:0]                 imm_i;
        logic [31:0]                 imm_j;
        logic [2:0]                  funct3;
        alu_ctrl_t                   alu_ctrl;
        alu_res_t                    alu_res;
        res_src_t                    res_src;
        src_op2_t                    op2_src;
        logic                        op1_src;
        logic                        reg_write;
        logic                        jal;
        logic                        jalr;
        logic                        mret;
        logic                        branch;
        logic                        store;
        logic                        to_trap;
        logic                        branch_pred;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             in_entry;
    entry_t             head;
    logic               push, pop, not_empty;
    logic [31:0]        op1_pc;
    logic [IADDR_SPACE_BITS-1:1] tgt_base, tgt_off;

    assign not_empty = (count_q != '0);
    assign o_valid   = not_empty;
    assign o_ready   = (count_q != CNT_W'(DEPTH));
    assign o_count   = count_q;
    assign push      = i_valid & o_ready & ~i_flush;
    assign pop       = o_valid & i_ready & ~i_flush;

    always_comb begin
        in_entry = '{pc: i_pc, pc_next: i_pc_next, rs1: i_rs1, rs2: i_rs2, rd: i_rd,
                     imm_i: i_imm_i, imm_j: i_imm_j, funct3: i_funct3,
                     alu_ctrl: i_alu_ctrl, alu_res: i_alu_res, res_src: i_res_src,
                     op2_src: i_op2_src, op1_src: i_op1_src, reg_write: i_reg_write,
                     jal: i_inst_jal, jalr: i_inst_jalr, mret: i_inst_mret,
                     branch: i_inst_branch, store: i_inst_store, to_trap: i_to_trap,
                     branch_pred: i_branch_pred};
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            case ({push, pop})
                2'b10:   count_d = CNT_W'(count_q + 1'b1);
                2'b01:   count_d = CNT_W'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Control fields read as zero while empty; data fields pass through unqualified.
    always_comb begin
        o_rs1           = head.rs1;
        o_rs2           = head.rs2;
        o_funct3        = head.funct3;
        o_res           = head.alu_res;
        o_res_src       = head.res_src;
        o_pc            = head.pc;
        o_pc_next       = head.pc_next;
        o_rd            = not_empty ? head.rd : 5'd0;
        o_alu_ctrl      = not_empty ? head.alu_ctrl : '0;
        o_branch_pred   = not_empty & head.branch_pred;
        o_reg_write     = not_empty & head.reg_write;
        o_store         = not_empty & head.store;
        o_inst_branch   = not_empty & head.branch;
        o_to_trap       = not_empty & head.to_trap;
        o_inst_jal_jalr = not_empty & (head.jal | head.jalr | head.mret);
        o_reg_data1     = i_reg1_data;
        o_reg_data2     = i_reg2_data;
    end

    always_comb begin
        op1_pc = 32'({head.pc, 1'b0});
        if (head.op1_src)               o_op1 = op1_pc;
        else if (head.alu_ctrl.div_mux) o_op1 = i_reg2_data;
        else                            o_op1 = i_reg1_data;

        if (head.op2_src.i)             o_op2 = head.imm_i;
        else if (head.op2_src.j)        o_op2 = head.imm_j;
        else if (head.alu_ctrl.div_mux) o_op2 = i_reg1_data;
        else                            o_op2 = i_reg2_data;
    end

    // Target arithmetic is in halfword units; the carry out of the top bit is dropped.
    always_comb begin
        if (head.mret) begin
            tgt_base = i_ret_addr;
            tgt_off  = '0;
        end else if (head.jalr) begin
            tgt_base = i_reg1_data[IADDR_SPACE_BITS-1:1];
            tgt_off  = head.imm_i[IADDR_SPACE_BITS-1:1];
        end else begin
            tgt_base = head.pc;
            tgt_off  = head.imm_j[IADDR_SPACE_BITS-1:1];
        end
        o_pc_target         = tgt_base + tgt_off;
        o_target_misaligned = NO_C & not_empty & ~head.mret & o_pc_target[1]
                              & (head.jal | head.jalr | head.branch);
    end
endmodule

// File: tb/tb_rv_alu1_fifo.sv
// Directed bench for rv_alu1_fifo (DEPTH=2, C_EXT=0): reset, fill/drain, streaming,
// target and operand muxing, and flush with a simultaneous push and pop.
module tb_rv_alu1_fifo;
    import rv_alu1_fifo_pkg::*;

    localparam int IA = 32;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_flush, i_valid, i_ready;
    logic          o_ready, o_valid;
    logic [IA-1:1] i_pc, i_pc_next, i_ret_addr;
    logic [4:0]    i_rs1, i_rs2, i_rd;
    logic [31:0]   i_imm_i, i_imm_j;
    logic [2:0]    i_funct3;
    alu_ctrl_t     i_alu_ctrl;
    alu_res_t      i_alu_res;
    res_src_t      i_res_src;
    src_op2_t      i_op2_src;
    logic          i_op1_src, i_reg_write, i_inst_jal, i_inst_jalr, i_inst_mret;
    logic          i_inst_branch, i_inst_store, i_to_trap, i_branch_pred;
    logic [31:0]   i_reg1_data, i_reg2_data;
    logic [4:0]    o_rs1, o_rs2, o_rd;
    logic [2:0]    o_funct3;
    alu_ctrl_t     o_alu_ctrl;
    alu_res_t      o_res;
    res_src_t      o_res_src;
    logic [IA-1:1] o_pc, o_pc_next, o_pc_target;
    logic          o_branch_pred, o_reg_write, o_store, o_inst_branch, o_to_trap;
    logic          o_inst_jal_jalr, o_target_misaligned;
    logic [31:0]   o_op1, o_op2, o_reg_data1, o_reg_data2;
    logic [1:0]    o_count;

    int checks = 0;
    int errors = 0;

    rv_alu1_fifo #(.IADDR_SPACE_BITS(IA), .DEPTH(2), .C_EXT(0)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_pc_next(i_pc_next), .i_ret_addr(i_ret_addr),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_imm_i(i_imm_i), .i_imm_j(i_imm_j), .i_funct3(i_funct3),
        .i_alu_ctrl(i_alu_ctrl), .i_alu_res(i_alu_res), .i_res_src(i_res_src),
        .i_op2_src(i_op2_src), .i_op1_src(i_op1_src), .i_reg_write(i_reg_write),
        .i_inst_jal(i_inst_jal), .i_inst_jalr(i_inst_jalr), .i_inst_mret(i_inst_mret),
        .i_inst_branch(i_inst_branch), .i_inst_store(i_inst_store),
        .i_to_trap(i_to_trap), .i_branch_pred(i_branch_pred),
        .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3),
        .o_alu_ctrl(o_alu_ctrl), .o_res(o_res), .o_res_src(o_res_src),
        .o_pc(o_pc), .o_pc_next(o_pc_next), .o_branch_pred(o_branch_pred),
        .o_reg_write(o_reg_write), .o_store(o_store), .o_inst_branch(o_inst_branch),
        .o_to_trap(o_to_trap), .o_inst_jal_jalr(o_inst_jal_jalr),
        .o_op1(o_op1), .o_op2(o_op2), .o_reg_data1(o_reg_data1), .o_reg_data2(o_reg_data2),
        .o_pc_target(o_pc_target), .o_target_misaligned(o_target_misaligned),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle just after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_entry();
        i_pc = '0; i_pc_next = '0; i_ret_addr = '0;
        i_rs1 = '0; i_rs2 = '0; i_rd = '0;
        i_imm_i = '0; i_imm_j = '0; i_funct3 = '0;
        i_alu_ctrl = '0; i_alu_res = '0; i_res_src = '0; i_op2_src = '0;
        i_op1_src = 0; i_reg_write = 0; i_inst_jal = 0; i_inst_jalr = 0;
        i_inst_mret = 0; i_inst_branch = 0; i_inst_store = 0; i_to_trap = 0;
        i_branch_pred = 0;
    endtask

    // Byte address -> halfword-indexed PC field.
    function automatic logic [IA-1:1] ba(input logic [31:0] a);
        return a[IA-1:1];
    endfunction

    initial begin
        i_reset_n = 1'b0; i_flush = 0; i_valid = 1; i_ready = 0;
        i_reg1_data = '0; i_reg2_data = '0;
        clear_entry();
        i_pc = ba(32'h400); i_reg_write = 1;

        // Reset held with i_valid high.
        step(); step();
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_count", o_count, 0);
        chk("rst_reg_write", o_reg_write, 0);
        chk("rst_jal_jalr", o_inst_jal_jalr, 0);
        i_reset_n = 1'b1; i_valid = 0;
        step();
        chk("post_rst_count", o_count, 0);

        // Fill with downstream stalled.
        clear_entry();
        i_valid = 1; i_ready = 0; i_reg_write = 1; i_rd = 5'd3;
        i_pc = ba(32'h100);
        step();
        chk("fill1_count", o_count, 1);
        chk("fill1_valid", o_valid, 1);
        chk("fill1_pc", {o_pc, 1'b0}, 32'h100);
        chk("fill1_reg_write", o_reg_write, 1);
        chk("fill1_rd", o_rd, 3);
        i_pc = ba(32'h104);
        step();
        chk("fill2_count", o_count, 2);
        chk("fill2_ready", o_ready, 0);
        i_pc = ba(32'h108);
        step();
        chk("full_count", o_count, 2);
        chk("full_head_pc", {o_pc, 1'b0}, 32'h100);
        i_valid = 0; i_ready = 1;
        step();
        chk("drain1_pc", {o_pc, 1'b0}, 32'h104);
        chk("drain1_count", o_count, 1);
        step();
        chk("drain2_count", o_count, 0);
        chk("drain2_valid", o_valid, 0);
        chk("drain2_reg_write", o_reg_write, 0);
        chk("drain2_rd", o_rd, 0);

        // Streaming: each entry is at the head one edge after it is pushed.
        i_valid = 1; i_ready = 1;
        for (int k = 0; k < 8; k++) begin
            i_pc = ba(32'h300 + 32'(4 * k));
            step();
            chk("stream_pc", {o_pc, 1'b0}, 32'h300 + 32'(4 * k));
            chk("stream_count", o_count, 1);
            chk("stream_valid", o_valid, 1);
        end

        // Targets and operands: i_ready=1 keeps the latest push at the head.
        clear_entry();
        i_inst_jal = 1; i_pc = ba(32'h200); i_imm_j = 32'hFFFF_FFF0;
        step();
        chk("jal_target", {o_pc_target, 1'b0}, 32'h1F0);
        chk("jal_misaligned", o_target_misaligned, 0);
        chk("jal_jj", o_inst_jal_jalr, 1);

        clear_entry();
        i_inst_jalr = 1; i_imm_i = 32'd4; i_reg1_data = 32'h1003;
        step();
        chk("jalr_target", {o_pc_target, 1'b0}, 32'h1006);
        chk("jalr_misaligned", o_target_misaligned, 1);

        clear_entry();
        i_inst_mret = 1; i_ret_addr = ba(32'h80); i_imm_j = 32'h2;
        step();
        chk("mret_target", {o_pc_target, 1'b0}, 32'h80);
        chk("mret_misaligned", o_target_misaligned, 0);
        chk("mret_jj", o_inst_jal_jalr, 1);

        clear_entry();
        i_inst_branch = 1; i_pc = ba(32'h10); i_imm_j = 32'd6;
        step();
        chk("br_target", {o_pc_target, 1'b0}, 32'h16);
        chk("br_misaligned", o_target_misaligned, 1);
        chk("br_flag", o_inst_branch, 1);

        clear_entry();
        i_alu_ctrl.div_mux = 1; i_reg1_data = 32'd7; i_reg2_data = 32'd9;
        step();
        chk("div_op1", o_op1, 9);
        chk("div_op2", o_op2, 7);
        chk("div_alu_ctrl", o_alu_ctrl, 5'b0000_1);

        clear_entry();
        i_reg1_data = 32'h11; i_reg2_data = 32'h22;
        step();
        chk("plain_op1", o_op1, 32'h11);
        chk("plain_op2", o_op2, 32'h22);

        clear_entry();
        i_op1_src = 1; i_pc = ba(32'h40); i_op2_src.i = 1; i_imm_i = 32'h123;
        step();
        chk("pc_op1", o_op1, 32'h40);
        chk("immi_op2", o_op2, 32'h123);

        clear_entry();
        i_op2_src.j = 1; i_imm_j = 32'h456; i_alu_ctrl = '{op: 4'h5, div_mux: 1'b0};
        i_inst_store = 1; i_to_trap = 1; i_branch_pred = 1;
        step();
        chk("immj_op2", o_op2, 32'h456);
        chk("store_flag", o_store, 1);
        chk("trap_flag", o_to_trap, 1);
        chk("bpred_flag", o_branch_pred, 1);

        i_valid = 0;
        step();
        chk("empty_valid", o_valid, 0);
        chk("empty_alu_ctrl", o_alu_ctrl, 0);
        chk("empty_store", o_store, 0);
        chk("empty_bpred", o_branch_pred, 0);

        // Flush while full with a push and pop attempted on the same edge.
        clear_entry();
        i_ready = 0; i_valid = 1; i_rd = 5'd9; i_reg_write = 1;
        i_pc = ba(32'h500);
        step();
        i_pc = ba(32'h504);
        step();
        chk("pre_flush_count", o_count, 2);
        i_pc = ba(32'h508); i_ready = 1; i_flush = 1;
        step();
        chk("flush_count", o_count, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        chk("flush_reg_write", o_reg_write, 0);
        i_flush = 0; i_valid = 0;
        step();
        chk("post_flush_count", o_count, 0);
        chk("post_flush_valid", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
